// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_pkg
//  Description : Shared encodings for the data-memory load/store unit:
//                access-size (BHW) codes, flush FSM states, lane constants.
//  Revision    : 1.0  initial release
// ============================================================================
package data_mem_pkg;

   // Access size as presented on i_bhw; the reserved code behaves as a word.
   typedef enum logic [1:0] {
      BHW_BYTE     = 2'b00,
      BHW_HALFWORD = 2'b01,
      BHW_RSVD     = 2'b10,
      BHW_WORD     = 2'b11
   } bhw_e;

   // Memory-clear sequencer states.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } state_e;

   localparam int LANE_BITS = 8;
   localparam int HALF_BITS = 16;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_lsu_if
//  Description : Request/response bundle of the data-memory LSU.
//                master : requester (drives loads/stores/flush/debug addr)
//                slave  : memory (returns load data, strobes, busy, debug word)
//  Ports       : i_mem_read, i_mem_write, i_bhw, i_unsigned, i_addr, i_data,
//                i_flush, i_debug_addr -> slave
//                o_data, o_data_valid, o_misaligned, o_busy, o_debug_mem
//                -> master
//  Revision    : 1.0  initial release
// ============================================================================
interface data_mem_lsu_if #(
   parameter int B = 32,
   parameter int W = 7
);
   logic         i_mem_read;
   logic         i_mem_write;
   logic [1:0]   i_bhw;
   logic         i_unsigned;
   logic [W-1:0] i_addr;
   logic [B-1:0] i_data;
   logic         i_flush;
   logic [W-1:0] i_debug_addr;
   logic [B-1:0] o_data;
   logic         o_data_valid;
   logic         o_misaligned;
   logic         o_busy;
   logic [B-1:0] o_debug_mem;

   modport master (
      output i_mem_read, i_mem_write, i_bhw, i_unsigned, i_addr, i_data,
             i_flush, i_debug_addr,
      input  o_data, o_data_valid, o_misaligned, o_busy, o_debug_mem
   );

   modport slave (
      input  i_mem_read, i_mem_write, i_bhw, i_unsigned, i_addr, i_data,
             i_flush, i_debug_addr,
      output o_data, o_data_valid, o_misaligned, o_busy, o_debug_mem
   );
endinterface : data_mem_lsu_if
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Combinational load formatter. Selects the addressed byte or
//                halfword from a memory word, moves it to bit 0 and sign- or
//                zero-extends it. Word accesses pass the word through.
//  Ports       : i_word     memory word
//                i_off      byte lane offset within the word
//                i_bhw      access size
//                i_unsigned 1 = zero-extend, 0 = sign-extend
//                o_data     formatted load result
//  Revision    : 1.0  initial release
// ============================================================================
module mem_load_align
   import data_mem_pkg::*;
#(
   parameter int B  = 32,
   parameter int OB = 2
) (
   input  wire logic [B-1:0]  i_word,
   input  wire logic [OB-1:0] i_off,
   input  wire logic [1:0]    i_bhw,
   input  wire logic          i_unsigned,
   output logic      [B-1:0]  o_data
);

   // Only the low halfword of the shifted word is ever consumed.
   logic [HALF_BITS-1:0] w_lo;
   assign w_lo = HALF_BITS'(i_word >> {i_off, 3'b000});

   always_comb begin
      o_data = i_word;
      case (i_bhw)
         BHW_BYTE:
            o_data = i_unsigned ? B'(w_lo[LANE_BITS-1:0])
                                : {{(B-LANE_BITS){w_lo[LANE_BITS-1]}}, w_lo[LANE_BITS-1:0]};
         BHW_HALFWORD:
            o_data = i_unsigned ? B'(w_lo)
                                : {{(B-HALF_BITS){w_lo[HALF_BITS-1]}}, w_lo};
         default:
            o_data = i_word;
      endcase
   end

endmodule : mem_load_align
`default_nettype wire

// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_lsu
//  Description : Byte-addressable data memory with load/store unit.
//                Byte/halfword/word stores with lane enables, 1-cycle
//                registered loads with sign/zero extension, alignment check,
//                a sequenced memory clear (flush) and a combinational debug
//                read port.
//  Ports       : i_clk    clock
//                i_reset  asynchronous active-high reset
//                bus      data_mem_lsu_if.slave request/response bundle
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_lsu
   import data_mem_pkg::*;
#(
   parameter int B = 32,
   parameter int W = 7
) (
   input wire logic        i_clk,
   input wire logic        i_reset,
   data_mem_lsu_if.slave   bus
);

   localparam int NB    = B / 8;
   localparam int OB    = $clog2(NB);
   localparam int WI    = W - OB;
   localparam int DEPTH = 2 ** WI;

   // Storage is deliberately outside the reset domain.
   logic [B-1:0]  mem_q [DEPTH];

   state_e        state_q, state_d;
   logic [WI-1:0] cnt_q, cnt_d;
   logic [B-1:0]  data_q, data_d;
   logic          valid_q, valid_d;
   logic          mis_q, mis_d;

   logic [WI-1:0] w_idx;
   logic [OB-1:0] w_off;
   logic          w_mis;
   logic          w_accept;
   logic          w_do_write;
   logic          w_do_load;
   logic          w_mis_pulse;
   logic [NB-1:0] w_be;
   logic [B-1:0]  w_wdata;
   logic [B-1:0]  w_load_data;
   logic          w_unused_dbg;

   assign w_idx = bus.i_addr[W-1:OB];
   assign w_off = bus.i_addr[OB-1:0];

   always_comb begin
      w_mis = 1'b0;
      case (bus.i_bhw)
         BHW_BYTE:     w_mis = 1'b0;
         BHW_HALFWORD: w_mis = bus.i_addr[0];
         default:      w_mis = (w_off != '0);
      endcase
   end

   // Requests are only honoured in IDLE and lose to a simultaneous flush.
   assign w_accept    = (state_q == ST_IDLE) && !bus.i_flush;
   assign w_do_write  = w_accept && bus.i_mem_write && !w_mis;
   assign w_do_load   = w_accept && bus.i_mem_read && !bus.i_mem_write && !w_mis;
   assign w_mis_pulse = w_accept && (bus.i_mem_read || bus.i_mem_write) && w_mis;

   // Lane enables and store data placed on the addressed lanes.
   always_comb begin
      w_be    = '1;
      w_wdata = bus.i_data;
      case (bus.i_bhw)
         BHW_BYTE: begin
            w_be    = NB'(1) << w_off;
            w_wdata = B'(bus.i_data[LANE_BITS-1:0]) << {w_off, 3'b000};
         end
         BHW_HALFWORD: begin
            w_be    = NB'(3) << w_off;
            w_wdata = B'(bus.i_data[HALF_BITS-1:0]) << {w_off, 3'b000};
         end
         default: begin
            w_be    = '1;
            w_wdata = bus.i_data;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (state_q == ST_FLUSH) begin
         mem_q[cnt_q] <= '0;
      end else if (w_do_write) begin
         for (int l = 0; l < NB; l++) begin
            if (w_be[l]) begin
               mem_q[w_idx][LANE_BITS*l +: LANE_BITS] <= w_wdata[LANE_BITS*l +: LANE_BITS];
            end
         end
      end
   end

   mem_load_align #(
      .B  (B),
      .OB (OB)
   ) u_align (
      .i_word     (mem_q[w_idx]),
      .i_off      (w_off),
      .i_bhw      (bus.i_bhw),
      .i_unsigned (bus.i_unsigned),
      .o_data     (w_load_data)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_flush) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end else begin
               valid_d = w_do_load;
               mis_d   = w_mis_pulse;
               if (w_do_load) begin
                  data_d = w_load_data;
               end
            end
         end
         ST_FLUSH: begin
            // DEPTH is a power of two, so all-ones marks the last word.
            if (&cnt_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.o_data       = data_q;
   assign bus.o_data_valid = valid_q;
   assign bus.o_misaligned = mis_q;
   assign bus.o_busy       = (state_q == ST_FLUSH);
   assign bus.o_debug_mem  = mem_q[bus.i_debug_addr[W-1:OB]];

   // Debug port is word-granular; the lane bits carry no meaning here.
   assign w_unused_dbg = ^bus.i_debug_addr[OB-1:0];

endmodule : data_mem_lsu
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_lsu
//  Description : Scoreboard testbench for data_mem_lsu (B=32, W=7, 32 words).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_lsu;
   import data_mem_pkg::*;

   localparam int B     = 32;
   localparam int W     = 7;
   localparam int DEPTH = 32;

   typedef struct {
      bit          mis;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   data_mem_lsu_if #(.B(B), .W(W)) bus ();

   data_mem_lsu #(.B(B), .W(W)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every valid or misaligned strobe must match the queue head.
   always @(negedge clk) begin
      if (!rst && (bus.o_data_valid || bus.o_misaligned)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_resp: got valid=%0b mis=%0b data=%h, required no response",
                     bus.o_data_valid, bus.o_misaligned, bus.o_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.mis) begin
               if (!(bus.o_misaligned && !bus.o_data_valid)) begin
                  n_err++;
                  $display("FAIL misaligned_resp: got valid=%0b mis=%0b, required valid=0 mis=1",
                           bus.o_data_valid, bus.o_misaligned);
               end
            end else if (!(bus.o_data_valid && !bus.o_misaligned && bus.o_data == e.data)) begin
               n_err++;
               $display("FAIL load_resp: got valid=%0b mis=%0b data=%h, required valid=1 mis=0 data=%h",
                        bus.o_data_valid, bus.o_misaligned, bus.o_data, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic clear_req();
      bus.i_mem_read  = 1'b0;
      bus.i_mem_write = 1'b0;
      bus.i_bhw       = BHW_WORD;
      bus.i_unsigned  = 1'b0;
      bus.i_addr      = '0;
      bus.i_data      = '0;
      bus.i_flush     = 1'b0;
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; holds the request across one edge.
   task automatic do_req(input bit rd, input bit wr, input logic [1:0] bhw, input bit uns,
                         input logic [6:0] addr, input logic [31:0] data);
      bus.i_mem_read  = rd;
      bus.i_mem_write = wr;
      bus.i_bhw       = bhw;
      bus.i_unsigned  = uns;
      bus.i_addr      = addr;
      bus.i_data      = data;
      sync();
      clear_req();
   endtask

   task automatic store(input logic [1:0] bhw, input logic [6:0] addr, input logic [31:0] data);
      do_req(1'b0, 1'b1, bhw, 1'b0, addr, data);
   endtask

   task automatic load(input logic [1:0] bhw, input bit uns, input logic [6:0] addr,
                       input logic [31:0] exp);
      exp_q.push_back('{mis: 1'b0, data: exp});
      do_req(1'b1, 1'b0, bhw, uns, addr, '0);
   endtask

   task automatic expect_mis(input bit rd, input bit wr, input logic [1:0] bhw,
                             input logic [6:0] addr, input logic [31:0] data);
      exp_q.push_back('{mis: 1'b1, data: '0});
      do_req(rd, wr, bhw, 1'b0, addr, data);
   endtask

   task automatic dbg(input string name, input logic [6:0] addr, input logic [31:0] exp);
      bus.i_debug_addr = addr;
      #1;
      chk(name, bus.o_debug_mem, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cnt;
      int bad_words;
      clear_req();
      bus.i_debug_addr = '0;
      rst = 1'b1;
      #3;
      chk("rst_o_data",   bus.o_data, 32'h0);
      chk("rst_valid",    {31'd0, bus.o_data_valid}, 32'h0);
      chk("rst_mis",      {31'd0, bus.o_misaligned}, 32'h0);
      chk("rst_busy",     {31'd0, bus.o_busy}, 32'h0);
      #4 rst = 1'b0;
      sync();

      // Byte/halfword/word access and extension.
      store(BHW_WORD, 7'd0, 32'h1122_3344);
      load(BHW_BYTE, 1'b0, 7'd3, 32'h0000_0011);
      load(BHW_BYTE, 1'b0, 7'd0, 32'h0000_0044);
      load(BHW_HALFWORD, 1'b1, 7'd2, 32'h0000_1122);
      load(BHW_WORD, 1'b0, 7'd0, 32'h1122_3344);
      store(BHW_WORD, 7'd4, 32'h0000_0000);
      store(BHW_BYTE, 7'd5, 32'hFFFF_FF80);
      load(BHW_BYTE, 1'b0, 7'd5, 32'hFFFF_FF80);
      load(BHW_BYTE, 1'b1, 7'd5, 32'h0000_0080);
      load(BHW_HALFWORD, 1'b0, 7'd4, 32'hFFFF_8000);
      load(BHW_HALFWORD, 1'b1, 7'd4, 32'h0000_8000);
      dbg("dbg_word1", 7'd6, 32'h0000_8000);

      // Alignment rejection.
      expect_mis(1'b1, 1'b0, BHW_WORD, 7'd2, '0);
      expect_mis(1'b0, 1'b1, BHW_HALFWORD, 7'd1, 32'h0000_BEEF);
      dbg("dbg_after_bad_sh", 7'd0, 32'h1122_3344);
      store(BHW_HALFWORD, 7'd2, 32'h0000_BEEF);
      dbg("dbg_after_sh", 7'd1, 32'hBEEF_3344);
      load(BHW_RSVD, 1'b1, 7'd0, 32'hBEEF_3344);
      expect_mis(1'b1, 1'b0, BHW_RSVD, 7'd1, '0);

      // Read+write together: write wins, no response.
      do_req(1'b1, 1'b1, BHW_WORD, 1'b0, 7'd8, 32'hCAFE_F00D);
      load(BHW_WORD, 1'b0, 7'd8, 32'hCAFE_F00D);
      store(BHW_BYTE, 7'd9, 32'h0000_0055);
      chk("o_data_hold", bus.o_data, 32'hCAFE_F00D);
      load(BHW_WORD, 1'b0, 7'd8, 32'hCAFE_550D);

      // Flush: fill, clear, count busy cycles, requests ignored meanwhile.
      for (int i = 0; i < DEPTH; i++) store(BHW_WORD, 7'(i * 4), 32'hA500_0000 | i);
      bus.i_flush = 1'b1;
      sync();
      bus.i_flush = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!bus.o_busy) break;
         busy_cnt++;
         if (k == 2) begin
            bus.i_mem_write = 1'b1; bus.i_bhw = BHW_WORD;
            bus.i_addr = 7'd12;     bus.i_data = 32'hDEAD_BEEF;
         end else if (k == 3) begin
            clear_req();
            bus.i_mem_read = 1'b1;  bus.i_addr = 7'd16;
         end else if (k == 4) begin
            clear_req();
            bus.i_mem_read = 1'b1;  bus.i_bhw = BHW_WORD; bus.i_addr = 7'd2;
         end else if (k == 5) begin
            clear_req();
         end
      end
      clear_req();
      chk("flush_busy_cycles", busy_cnt, DEPTH);
      sync();
      bad_words = 0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.i_debug_addr = 7'(i * 4);
         #1;
         if (bus.o_debug_mem !== 32'h0) bad_words++;
      end
      chk("flush_nonzero_words", bad_words, 0);
      sync();
      dbg("flush_word3", 7'd12, 32'h0);

      // Reset mid-flush; simultaneous store must be dropped.
      sync();
      for (int i = 0; i < DEPTH; i++) store(BHW_WORD, 7'(i * 4), 32'h5A00_0000 | i);
      bus.i_flush = 1'b1;
      bus.i_mem_write = 1'b1; bus.i_bhw = BHW_WORD;
      bus.i_addr = 7'd80;     bus.i_data = 32'h1234_5678;
      sync();
      clear_req();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_busy", {31'd0, bus.o_busy}, 32'h0);
      chk("rst_mid_o_data", bus.o_data, 32'h0);
      #1 rst = 1'b0;
      sync();
      bad_words = 0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.i_debug_addr = 7'(i * 4);
         #1;
         if (bus.o_debug_mem !== ((i < 3) ? 32'h0 : (32'h5A00_0000 | i))) bad_words++;
      end
      chk("rst_mid_bad_words", bad_words, 0);
      sync();
      dbg("rst_mid_word2", 7'd8, 32'h0);
      dbg("rst_mid_word3", 7'd12, 32'h5A00_0003);
      dbg("rst_mid_word20", 7'd80, 32'h5A00_0014);
      sync();
      load(BHW_WORD, 1'b0, 7'd12, 32'h5A00_0003);

      repeat (3) sync();
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_data_mem_lsu
`default_nettype wire
